fifo_sync_flex: RTL
===================

Name: fifo_sync_flex

Overview:
Register-based synchronous FIFO, next generation of the team's sync FIFO. Depth is any integer ≥ 2; power-of-two depth is not required. Adds an occupancy output, programmable almost-full and almost-empty flags, a synchronous flush, a sticky overflow flag and a high-water mark. It sits between a producer and a consumer in one clock domain, using the enable/ready handshake on both sides.

Parameters:
WIDTH, 8, data width in bits (≥1).
DEPTH, 8, number of entries (≥2, any integer).
AFULL_LEVEL, DEPTH-1, almost_full asserts when count ≥ AFULL_LEVEL (range 1..DEPTH).
AEMPTY_LEVEL, 1, almost_empty asserts when count ≤ AEMPTY_LEVEL (range 0..DEPTH-1).

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous discard of all stored entries.
stats_clear  in  1  synchronous clear of overflow and max_count.
in_data  in  WIDTH  write data.
in_enable  in  1  producer presents in_data.
in_ready  out  1  FIFO can accept a write this cycle.
out_data  out  WIDTH  head-of-FIFO data.
out_enable  out  1  out_data is valid.
out_ready  in  1  consumer accepts out_data.
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
almost_full  out  1  count ≥ AFULL_LEVEL.
almost_empty  out  1  count ≤ AEMPTY_LEVEL.
overflow  out  1  sticky: a write was attempted while full.
max_count  out  $clog2(DEPTH+1)  highest count reached since reset or stats_clear.

Behaviour:
- Reset (async assert, released synchronously by the environment): wr_ptr = rd_ptr = 0, count = 0, overflow = 0, max_count = 0. Outputs at reset: in_ready = 1, out_enable = 0, almost_full = 0, almost_empty = 1. Memory contents are not reset; out_data is don't-care while out_enable = 0.
- Pointers are 0..DEPTH-1 and wrap explicitly: ptr == DEPTH-1 → 0. There is no extra MSB. Full and empty are derived from the count register.
- in_ready = (count != DEPTH). out_enable = (count != 0). Both are combinational from registered state only; neither depends on in_enable or out_ready.
- Write fires when in_enable && in_ready: mem[wr_ptr] ← in_data, wr_ptr advances.
- Read fires when out_enable && out_ready: rd_ptr advances.
- out_data = mem[rd_ptr], combinational (first-word fall-through).
- Latency: a word written at edge N is visible with out_enable = 1 from edge N+1 when the FIFO was empty. There is no same-cycle pass-through.
- Simultaneous write and read fire: count unchanged, both pointers advance.
- When full, in_ready = 0. A read in the same cycle frees space only from the next cycle; no write is accepted into a full FIFO in that cycle.
- Count next-state: +1 on write only, −1 on read only, unchanged otherwise.
- flush = 1: pointers and count go to 0 at the edge. Flush overrides any write or read firing in that cycle; that write is discarded and does not set overflow. Flush does not alter overflow or max_count.
- overflow: set at the edge when in_enable && !in_ready && !flush. Cleared only by reset or stats_clear. If set and clear occur together, set wins.
- max_count: updated to count_next when count_next > max_count. stats_clear loads max_count with count_next, not 0.
- almost_full and almost_empty are combinational compares on the registered count.

Optional Feature:
FIFO_SYNC_FLEX_DROP_COUNT_EN.
- Defined: adds output drop_count (16 bits). It increments on every cycle in which a write is rejected (in_enable && !in_ready && !flush), saturates at 16'hFFFF, and clears on reset or stats_clear (increment wins over clear). The block also emits a simulation-only $display warning when in_data changes while in_enable = 1 and in_ready = 0.
- Undefined: drop_count is absent and no warning logic is generated. All other behaviour is identical.

Test Plan:
- Basic fill/drain (DEPTH=5, non-power-of-two), out_ready = 0: write 0x01..0x05 → count 1..5, in_ready = 0 after the 5th write, almost_full from count 4. Then out_ready = 1 → reads 0x01..0x05 in order, out_enable = 0 after the last read, max_count = 5.
- Wrap-around (DEPTH=5): 12 writes, each read back 2 cycles later, continuous stream → all 12 values emerge in order, count never exceeds 3, no overflow.
- Full plus simultaneous read/write: fill to 5, drive in_enable and out_ready together for 3 cycles → the first cycle pops only (count 4, overflow = 1); the next cycles hold count at 4 with data ordered correctly.
- Flush: 3 entries stored, flush together with in_enable (0xAA) → count = 0 next cycle, out_enable = 0, 0xAA is never output, overflow unchanged, max_count still 3.
- Stats and reset: cause overflow, assert stats_clear with 2 entries stored → overflow = 0, max_count = 2. Assert reset asynchronously mid-stream (between edges) → count, in_ready = 1 and out_enable = 0 take effect immediately, without waiting for a clock edge.
- With FIFO_SYNC_FLEX_DROP_COUNT_EN: hold in_enable for 7 cycles while full → drop_count = 7. Preload near saturation via 65540 rejected writes → drop_count holds at 0xFFFF.

Source files
------------

// File: rtl/fifo_sync_flex.sv
// Register-based synchronous FIFO for any DEPTH >= 2, with occupancy, almost flags, flush and stats.
// Optional rejected-write counter enabled by defining FIFO_SYNC_FLEX_DROP_COUNT_EN.
module fifo_sync_flex #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
    parameter int unsigned AEMPTY_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         stats_clear,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_enable,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_enable,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   max_count
`ifdef FIFO_SYNC_FLEX_DROP_COUNT_EN
    ,
    output logic [15:0]                  drop_count
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    max_count_q, max_count_d;
    logic             overflow_q, overflow_d;
    logic             wr_fire, rd_fire, wr_reject;

    assign in_ready     = (count_q != CW'(DEPTH));
    assign out_enable   = (count_q != '0);
    assign out_data     = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= CW'(AFULL_LEVEL));
    assign almost_empty = (count_q <= CW'(AEMPTY_LEVEL));
    assign overflow     = overflow_q;
    assign max_count    = max_count_q;

    assign wr_fire   = in_enable && in_ready;
    assign rd_fire   = out_enable && out_ready;
    assign wr_reject = in_enable && !in_ready && !flush;

    // Pointer, occupancy and statistics next-state; flush overrides both ports
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        max_count_d = max_count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (wr_reject) begin
            overflow_d = 1'b1;
        end else if (stats_clear) begin
            overflow_d = 1'b0;
        end

        if (stats_clear || (count_d > max_count_q)) begin
            max_count_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            max_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            max_count_q <= max_count_d;
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef FIFO_SYNC_FLEX_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    assign drop_count = drop_count_q;

    always_comb begin
        drop_count_d = drop_count_q;
        if (wr_reject) begin
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (stats_clear) begin
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

`ifndef SYNTHESIS
    // Producer must hold in_data stable while stalled
    logic [WIDTH-1:0] stall_data_q;
    logic             stalled_q;

    always_ff @(posedge clk) begin
        stalled_q    <= in_enable && !in_ready && !reset;
        stall_data_q <= in_data;
        if (stalled_q && in_enable && !in_ready && (in_data != stall_data_q)) begin
            $display("fifo_sync_flex warning: in_data changed while stalled at %0t", $time);
        end
    end
`endif
`endif

endmodule
